// File: rtl/count_day_if.sv
// Day-counter bus: carry/adjust controls and month context in, BCD day and carries out.
interface count_day_if #(
  parameter int unsigned MAX_DISPLAY_UNIT = 4,
  parameter int unsigned MAX_DISPLAY_TEN  = 2
);
  logic                        en_d;
  logic                        set_mode;
  logic                        up;
  logic                        down;
  logic [3:0]                  month_unit;
  logic [1:0]                  month_ten;
  logic                        leap;
  logic [MAX_DISPLAY_UNIT-1:0] day_unit;
  logic [MAX_DISPLAY_TEN-1:0]  day_ten;
  logic                        day_last;
  logic                        pulse_d;

  modport master (
    output en_d, set_mode, up, down, month_unit, month_ten, leap,
    input  day_unit, day_ten, day_last, pulse_d
  );

  modport slave (
    input  en_d, set_mode, up, down, month_unit, month_ten, leap,
    output day_unit, day_ten, day_last, pulse_d
  );
endinterface

// File: rtl/count_day.sv
// BCD day-of-month counter: advances on the daily carry, wraps at the month's
// last day (month/leap dependent) and issues the month carry on wrap.
module count_day #(
  parameter int unsigned MAX_DISPLAY_UNIT = 4,
  parameter int unsigned MAX_DISPLAY_TEN  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  count_day_if.slave  bus
);
  localparam int unsigned UW    = MAX_DISPLAY_UNIT;
  localparam int unsigned TW    = MAX_DISPLAY_TEN;
  localparam int unsigned DAY_W = UW + TW;

  logic [UW-1:0]    unit_q, unit_d, last_unit, inc_unit, dec_unit;
  logic [TW-1:0]    ten_q, ten_d, last_ten, inc_ten, dec_ten;
  logic [DAY_W-1:0] day_code, last_code;
  logic             day_bad, over_last, at_last, at_first;

  // Last day of the current month; unknown month codes fall back to 31
  always_comb begin
    last_ten  = TW'(3);
    last_unit = UW'(1);
    case ({bus.month_ten, bus.month_unit})
      6'h04, 6'h06, 6'h09, 6'h11: last_unit = UW'(0);
      6'h02: begin
        last_ten  = TW'(2);
        last_unit = bus.leap ? UW'(9) : UW'(8);
      end
      default: ;
    endcase
  end

  assign day_code  = {ten_q, unit_q};
  assign last_code = {last_ten, last_unit};

  // BCD ordering matches numeric ordering once the unit digit is a valid digit
  assign day_bad   = (unit_q > UW'(9)) || (day_code == DAY_W'(0)) ||
                     (day_code > DAY_W'('h31));
  assign over_last = !day_bad && (day_code > last_code);
  assign at_last   = !day_bad && (day_code == last_code);
  assign at_first  = (day_code == DAY_W'(1));

  assign inc_unit = (unit_q == UW'(9)) ? UW'(0) : UW'(unit_q + UW'(1));
  assign inc_ten  = (unit_q == UW'(9)) ? TW'(ten_q + TW'(1)) : ten_q;
  assign dec_unit = (unit_q == UW'(0)) ? UW'(9) : UW'(unit_q - UW'(1));
  assign dec_ten  = (unit_q == UW'(0)) ? TW'(ten_q - TW'(1)) : ten_q;

  // Next day: corrections first, then manual adjust, then the daily carry
  always_comb begin
    ten_d  = ten_q;
    unit_d = unit_q;
    if (day_bad) begin
      ten_d  = TW'(0);
      unit_d = UW'(1);
    end else if (over_last) begin
      ten_d  = last_ten;
      unit_d = last_unit;
    end else if (bus.set_mode) begin
      if (bus.up && !bus.down) begin
        ten_d  = at_last ? TW'(0) : inc_ten;
        unit_d = at_last ? UW'(1) : inc_unit;
      end else if (bus.down && !bus.up) begin
        ten_d  = at_first ? last_ten  : dec_ten;
        unit_d = at_first ? last_unit : dec_unit;
      end
    end else if (bus.en_d) begin
      ten_d  = at_last ? TW'(0) : inc_ten;
      unit_d = at_last ? UW'(1) : inc_unit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ten_q  <= TW'(0);
      unit_q <= UW'(1);
    end else begin
      ten_q  <= ten_d;
      unit_q <= unit_d;
    end
  end

  assign bus.day_unit = unit_q;
  assign bus.day_ten  = ten_q;
  assign bus.day_last = at_last;
  assign bus.pulse_d  = bus.en_d && !bus.set_mode && at_last;
endmodule

// File: tb/tb_count_day.sv
// Scoreboard bench for count_day: directed scenarios plus random traffic
// against a calendar-level reference model.
module tb_count_day;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  count_day_if bus ();
  count_day dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    int    day;
    bit    last;
    bit    pulse;
    string tag;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;
  int   model_day = 1;

  function automatic int last_of(int mt, int mu, bit lp);
    int m;
    if (mu > 9) return 31;
    m = mt * 10 + mu;
    case (m)
      4, 6, 9, 11: return 30;
      2:           return lp ? 29 : 28;
      default:     return 31;
    endcase
  endfunction

  // One cycle: drive at the falling edge, queue expected outputs, advance model
  task automatic drive(bit r, bit en, bit st, bit u, bit dn, int mt, int mu, bit lp, string tag);
    exp_t e;
    int   lst;
    @(negedge clk);
    rst_n          = r;
    bus.en_d       = en;
    bus.set_mode   = st;
    bus.up         = u;
    bus.down       = dn;
    bus.month_ten  = 2'(mt);
    bus.month_unit = 4'(mu);
    bus.leap       = lp;
    lst = last_of(mt, mu, lp);
    if (!r) model_day = 1;
    e.day   = model_day;
    e.last  = (model_day == lst);
    e.pulse = r && en && !st && (model_day == lst);
    e.tag   = tag;
    q.push_back(e);
    if (r) begin
      if (model_day > lst) model_day = lst;
      else if (st) begin
        if (u && !dn)      model_day = (model_day == lst) ? 1 : model_day + 1;
        else if (dn && !u) model_day = (model_day == 1) ? lst : model_day - 1;
      end else if (en)     model_day = (model_day == lst) ? 1 : model_day + 1;
    end
  endtask

  task automatic en_n(int n, int mt, int mu, bit lp, string tag);
    for (int i = 0; i < n; i++) drive(1, 1, 0, 0, 0, mt, mu, lp, tag);
  endtask

  task automatic do_reset(int mt, int mu, string tag);
    drive(0, 0, 0, 0, 0, mt, mu, 0, tag);
  endtask

  // Monitor: compare presented outputs against the queue, away from the clock edge
  initial begin
    exp_t e;
    int   got;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e   = q.pop_front();
        got = int'(bus.day_ten) * 10 + int'(bus.day_unit);
        total++;
        if (got == e.day) passed++;
        else $display("FAIL %s day: got %0d expected %0d at %0t", e.tag, got, e.day, $time);
        total++;
        if (bus.day_last == e.last && bus.pulse_d == e.pulse) passed++;
        else $display("FAIL %s flags: got last=%0b pulse=%0b expected last=%0b pulse=%0b at %0t",
                      e.tag, bus.day_last, bus.pulse_d, e.last, e.pulse, $time);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int mt, mu, m;
    bit lp;
    rst_n = 1'b0;
    bus.en_d = 0; bus.set_mode = 0; bus.up = 0; bus.down = 0;
    bus.month_ten = 0; bus.month_unit = 1; bus.leap = 0;

    do_reset(0, 1, "reset");
    en_n(30, 0, 1, 0, "jan_count");
    en_n(1, 0, 1, 0, "jan_wrap");
    drive(1, 0, 0, 0, 0, 0, 1, 0, "jan_after");

    do_reset(0, 2, "feb_reset");
    en_n(27, 0, 2, 0, "feb_to28");
    en_n(1, 0, 2, 0, "feb28_wrap");
    drive(1, 0, 0, 0, 0, 0, 2, 0, "feb_after");
    do_reset(0, 2, "leap_reset");
    en_n(27, 0, 2, 1, "leap_to28");
    en_n(1, 0, 2, 1, "leap28_step");
    drive(1, 0, 0, 0, 0, 0, 2, 1, "leap29");

    do_reset(0, 1, "clamp_reset");
    en_n(30, 0, 1, 0, "clamp_to31");
    drive(1, 0, 0, 0, 0, 0, 4, 0, "clamp_apr");
    drive(1, 0, 0, 0, 0, 0, 4, 0, "clamp_apr30");
    drive(1, 1, 0, 0, 0, 0, 2, 0, "clamp_feb_en");
    drive(1, 0, 0, 0, 0, 0, 2, 0, "clamp_feb28");

    do_reset(1, 1, "set_reset");
    en_n(29, 1, 1, 0, "set_to30");
    drive(1, 0, 1, 1, 0, 1, 1, 0, "set_up_wrap");
    drive(1, 0, 1, 0, 1, 1, 1, 0, "set_down_wrap");
    drive(1, 0, 1, 1, 1, 1, 1, 0, "set_both");
    drive(1, 1, 1, 0, 0, 1, 1, 0, "set_en_ignored");
    drive(1, 0, 0, 1, 0, 1, 1, 0, "run_up_ignored");
    drive(1, 0, 0, 0, 0, 1, 1, 0, "set_exit");

    do_reset(0, 3, "bcd_reset");
    en_n(31, 0, 3, 0, "bcd_march");
    drive(1, 0, 0, 0, 0, 0, 3, 0, "bcd_after");

    do_reset(0, 1, "arst_reset");
    en_n(14, 0, 1, 0, "arst_to15");
    drive(0, 1, 0, 0, 0, 0, 1, 0, "arst_mid");
    en_n(3, 0, 1, 0, "arst_resume");

    mt = 0; mu = 1; lp = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 9) == 0) begin
          mt = $urandom_range(0, 3);
          mu = $urandom_range(0, 15);
        end else begin
          m  = $urandom_range(1, 12);
          mt = m / 10;
          mu = m % 10;
        end
      end
      if ($urandom_range(0, 19) == 0) lp = ~lp;
      if ($urandom_range(0, 199) == 0) do_reset(mt, mu, "rnd_reset");
      else drive(1, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mt, mu, lp, "rnd");
    end

    drive(1, 0, 0, 0, 0, mt, mu, lp, "final");
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #5;
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
